// File: rtl/man_mul_seq.sv
// Sequential shift-add mantissa multiplier with one-cycle normalise-and-round.
// The multiplier retires STEP bits per cycle, then produces a MAN_W-bit mantissa and exponent-adjust flags.
`timescale 1ns/1ps
module man_mul_seq #(
  parameter int MAN_W = 24,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] a,
  input  logic [MAN_W-1:0] b,
  input  logic [1:0]       rmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] man_out,
  output logic             exp_inc,
  output logic             rnd_ovf,
  output logic             inexact
);

  localparam int N     = MAN_W / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * MAN_W;

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [MAN_W-1:0]   b_q, b_d;
  logic [1:0]         rmode_q, rmode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [MAN_W-1:0]   man_out_q, man_out_d;
  logic               exp_inc_q, exp_inc_d;
  logic               rnd_ovf_q, rnd_ovf_d;
  logic               inexact_q, inexact_d;

  logic               norm, g_bit, r_bit, s_bit, inc;
  logic [MAN_W-1:0]   m_val;

  // NOTE: every _d gets a default before the case, so this block can never infer a latch.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    b_d         = b_q;
    rmode_d     = rmode_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    man_out_d   = man_out_q;
    exp_inc_d   = exp_inc_q;
    rnd_ovf_d   = rnd_ovf_q;
    inexact_d   = inexact_q;

    // Normalise: a product of two [1,2) mantissas lies in [1,4), so at most one extra bit.
    norm = acc_q[PW-1];
    if (norm) begin
      m_val = acc_q[PW-1:MAN_W];
      g_bit = acc_q[MAN_W-1];
      r_bit = acc_q[MAN_W-2];
      s_bit = |acc_q[MAN_W-3:0];
    end else begin
      m_val = acc_q[PW-2:MAN_W-1];
      g_bit = acc_q[MAN_W-2];
      r_bit = acc_q[MAN_W-3];
      s_bit = |acc_q[MAN_W-4:0];
    end

    case (rmode_q)
      2'd1:    inc = 1'b0;
      2'd2:    inc = g_bit | r_bit | s_bit;
      default: inc = g_bit & (r_bit | s_bit | m_val[0]);
    endcase

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d    = {{MAN_W{1'b0}}, a};
          b_d        = b;
          rmode_d    = rmode;
          acc_d      = '0;
          cnt_d      = CNT_W'(N - 1);
          in_ready_d = 1'b0;
          state_d    = MUL;
        end
      end
      MUL: begin
        for (int i = 0; i < STEP; i++) begin
          if (b_q[i]) acc_d = acc_d + (mcand_q << i);
        end
        mcand_d = mcand_q << STEP;
        b_d     = b_q >> STEP;
        if (cnt_q == '0) state_d = ROUND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ROUND: begin
        // Rounding an all-ones mantissa up wraps to 1.000..., which the exponent absorbs.
        if (inc && (&m_val)) begin
          man_out_d = {1'b1, {(MAN_W-1){1'b0}}};
          rnd_ovf_d = 1'b1;
        end else begin
          man_out_d = m_val + {{(MAN_W-1){1'b0}}, inc};
          rnd_ovf_d = 1'b0;
        end
        exp_inc_d   = norm;
        inexact_d   = g_bit | r_bit | s_bit;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only, so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      rmode_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      man_out_q   <= '0;
      exp_inc_q   <= 1'b0;
      rnd_ovf_q   <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      rmode_q     <= rmode_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      man_out_q   <= man_out_d;
      exp_inc_q   <= exp_inc_d;
      rnd_ovf_q   <= rnd_ovf_d;
      inexact_q   <= inexact_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign man_out   = man_out_q;
  assign exp_inc   = exp_inc_q;
  assign rnd_ovf   = rnd_ovf_q;
  assign inexact   = inexact_q;

endmodule

// File: doc/man_mul_seq.md
MAN_MUL_SEQ -- requirements
Module: man_mul_seq

Interface
REQ-001 SHALL provide parameter MAN_W, default 24, meaning mantissa width including the implicit bit; legal when MAN_W >= 4.
REQ-002 SHALL provide parameter STEP, default 1, meaning multiplier bits retired per MUL cycle; legal when STEP divides MAN_W.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: operands and mode are valid.
REQ-006 SHALL provide port in_ready, output, 1 bit: block can accept an operation.
REQ-007 SHALL provide port a, input, MAN_W bits: multiplicand mantissa.
REQ-008 SHALL provide port b, input, MAN_W bits: multiplier mantissa.
REQ-009 SHALL provide port rmode, input, 2 bits: 0=RNE, 1=RTZ, 2=RAZ (away from zero), 3=reserved, treated as RNE.
REQ-010 SHALL provide port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL provide port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL provide port man_out, output, MAN_W bits: rounded, normalised mantissa.
REQ-013 SHALL provide port exp_inc, output, 1 bit: product MSB set; exponent +1 from normalisation.
REQ-014 SHALL provide port rnd_ovf, output, 1 bit: rounding carried out; exponent +1 from rounding.
REQ-015 SHALL provide port inexact, output, 1 bit: G|R|S nonzero.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, ROUND, DONE; in_ready=1 only in IDLE.
REQ-017 SHALL, on accept (in_valid&in_ready in IDLE), latch a, b and rmode, clear the 2*MAN_W-bit accumulator, and go to MUL.
REQ-018 SHALL, in MUL, perform shift-add of STEP multiplier bits per cycle for exactly N=MAN_W/STEP cycles, then go to ROUND.
REQ-019 SHALL compute P=a*b exactly (2*MAN_W bits, unsigned, no truncation) by the end of MUL.
REQ-020 SHALL, in ROUND (1 cycle), apply the normalisation rule: norm=P[2W-1]; if norm: M=P[2W-1:W], G=P[W-1], R=P[W-2], S=|P[W-3:0]; else M=P[2W-2:W-1], G=P[W-2], R=P[W-3], S=|P[W-4:0].
REQ-021 SHALL compute the increment as: RNE inc=G&(R|S|M[0]); RTZ inc=0; RAZ inc=G|R|S.
REQ-022 SHALL, if inc and M is all ones, output man_out={1,0...0} with rnd_ovf=1; otherwise output man_out=M+inc with rnd_ovf=0.
REQ-023 SHALL set exp_inc=norm and inexact=G|R|S, registered with man_out on the ROUND->DONE edge.
REQ-024 SHALL make out_valid rise exactly N+1 rising edges after the accepting edge (N+1=25 for defaults).
REQ-025 SHALL, in DONE, hold out_valid=1 and all result outputs stable until out_ready=1, then go to IDLE on that edge.
REQ-026 SHALL ignore in_valid outside IDLE; no new operation is accepted in the DONE->IDLE cycle (in_ready=0 in DONE).
REQ-027 SHALL ignore out_ready when out_valid=0.
REQ-028 SHALL treat operands with MSB clear per REQ-020 without error; a=0 or b=0 yields man_out=0 and all flags 0.

Reset
REQ-029 SHALL, with rst=1 at a rising edge, enter IDLE, with out_valid=0, in_ready=1 after the edge, and man_out, exp_inc, rnd_ovf, inexact = 0.
REQ-030 SHALL give rst priority over all other inputs; reset during MUL/ROUND/DONE discards the operation with no out_valid pulse.

Verification
REQ-031 SHALL cover: defaults, a=b=0x800000, RNE -> man_out=0x800000, exp_inc=0, rnd_ovf=0, inexact=0, out_valid 25 edges after accept.
REQ-032 SHALL cover: a=0x800001, b=0xC00000 (tie, odd M=0xC00001) -> RNE 0xC00002, RTZ 0xC00001, RAZ 0xC00002; inexact=1, exp_inc=0.
REQ-033 SHALL cover: a=0x800003, b=0xC00000 (tie, even M=0xC00004) -> RNE 0xC00004, RAZ 0xC00005; a=b=0xFFFFFF RNE -> 0xFFFFFE, exp_inc=1, inexact=1.
REQ-034 SHALL cover: MAN_W=8, a=0x92, b=0xE0, RNE (P=0x7FC0) -> man_out=0x80, rnd_ovf=1, exp_inc=0, inexact=1.
REQ-035 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; result consumed on the first out_ready=1 edge.
REQ-036 SHALL cover: rst asserted mid-MUL and STEP in {1,4,8} -> no out_valid, IDLE next cycle, and latency N+1 matching a golden model over 10k random vectors.
